// File: rtl/div_pkg.sv
// Shared types and constants for the E-stage iterative divider.
package div_pkg;

    localparam int unsigned DIV_DATA_W = 32;
    localparam int unsigned DIV_CNT_W  = $clog2(DIV_DATA_W);
    localparam logic [DIV_DATA_W-1:0] DIV_ZERO_Q = {DIV_DATA_W{1'b1}};

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_BUSY,
        DIV_DONE
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract, keep on no borrow.
module div_step #(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_rem,
    input  logic [DATA_W-1:0] i_quo,
    input  logic [DATA_W-1:0] i_divisor,
    output logic [DATA_W-1:0] o_rem,
    output logic [DATA_W-1:0] o_quo
);

    logic [DATA_W:0] w_shift;
    logic [DATA_W:0] w_trial;
    logic            w_borrow;

    // Extra bit holds the shifted-out MSB so divisors above 2^(W-1) still work.
    always_comb begin
        w_shift  = {i_rem, i_quo[DATA_W-1]};
        w_trial  = w_shift - {1'b0, i_divisor};
        w_borrow = w_trial[DATA_W];
        o_rem    = w_borrow ? w_shift[DATA_W-1:0] : w_trial[DATA_W-1:0];
        o_quo    = {i_quo[DATA_W-2:0], ~w_borrow};
    end

endmodule

// File: rtl/div_unit_e.sv
// Execute-stage radix-2 restoring divider for div/divu; stalls E while busy, holds result in DONE.
module div_unit_e
    import div_pkg::*;
#(
    parameter int unsigned DATA_W = DIV_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              div_startE,
    input  logic              is_signedE,
    input  logic [DATA_W-1:0] src_aE,
    input  logic [DATA_W-1:0] src_bE,
    input  logic              flush_exceptionM,
    input  logic              ext_stallE,
    output logic              alu_stallE,
    output logic              div_validE,
    output logic [DATA_W-1:0] quotientE,
    output logic [DATA_W-1:0] remainderE
);

    localparam int unsigned CNT_W = $clog2(DATA_W);

    div_state_t        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_quo;
    logic [DATA_W-1:0] r_divisor;
    logic              r_signed;
    logic              r_a_sign;
    logic              r_b_sign;
    logic [DATA_W-1:0] r_q_out;
    logic [DATA_W-1:0] r_r_out;

    logic              w_start;
    logic              w_b_zero;
    logic              w_zero_start;
    logic [DATA_W-1:0] w_abs_a;
    logic [DATA_W-1:0] w_abs_b;
    logic [DATA_W-1:0] w_step_rem;
    logic [DATA_W-1:0] w_step_quo;
    logic [DATA_W-1:0] w_fix_q;
    logic [DATA_W-1:0] w_fix_r;

    always_comb begin
        w_start      = div_startE & ~flush_exceptionM;
        w_b_zero     = (src_bE == '0);
        w_zero_start = (r_state == DIV_IDLE) & w_start & w_b_zero;
        w_abs_a      = (is_signedE & src_aE[DATA_W-1]) ? -src_aE : src_aE;
        w_abs_b      = (is_signedE & src_bE[DATA_W-1]) ? -src_bE : src_bE;
        w_fix_q      = (r_signed & (r_a_sign ^ r_b_sign)) ? -w_step_quo : w_step_quo;
        w_fix_r      = (r_signed & r_a_sign) ? -w_step_rem : w_step_rem;
    end

    div_step #(
        .DATA_W (DATA_W)
    ) u_div_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_divisor),
        .o_rem     (w_step_rem),
        .o_quo     (w_step_quo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= DIV_IDLE;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_signed  <= 1'b0;
            r_a_sign  <= 1'b0;
            r_b_sign  <= 1'b0;
            r_q_out   <= '0;
            r_r_out   <= '0;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    if (w_start) begin
                        if (w_b_zero) begin
                            // Zero divisor only needs DONE when E cannot consume it this cycle.
                            if (ext_stallE) begin
                                r_state <= DIV_DONE;
                                r_q_out <= '1;
                                r_r_out <= src_aE;
                            end
                        end else begin
                            r_state   <= DIV_BUSY;
                            r_cnt     <= '0;
                            r_rem     <= '0;
                            r_quo     <= w_abs_a;
                            r_divisor <= w_abs_b;
                            r_signed  <= is_signedE;
                            r_a_sign  <= src_aE[DATA_W-1];
                            r_b_sign  <= src_bE[DATA_W-1];
                        end
                    end
                end
                DIV_BUSY: begin
                    if (flush_exceptionM) begin
                        r_state <= DIV_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_rem <= w_step_rem;
                        r_quo <= w_step_quo;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CNT_W'(DATA_W - 1)) begin
                            r_q_out <= w_fix_q;
                            r_r_out <= w_fix_r;
                            r_cnt   <= '0;
                            r_state <= DIV_DONE;
                        end
                    end
                end
                DIV_DONE: begin
                    if (flush_exceptionM || !ext_stallE) begin
                        r_state <= DIV_IDLE;
                    end
                end
                default: r_state <= DIV_IDLE;
            endcase
        end
    end

    always_comb begin
        alu_stallE = ((r_state == DIV_IDLE) & w_start & ~w_b_zero)
                   | ((r_state == DIV_BUSY) & ~flush_exceptionM);
        div_validE = (r_state == DIV_DONE) | w_zero_start;
        quotientE  = w_zero_start ? {DATA_W{1'b1}} : r_q_out;
        remainderE = w_zero_start ? src_aE : r_r_out;
    end

endmodule

// File: tb/tb_div_unit_e.sv
// Directed self-checking bench for div_unit_e: latency, signs, zero divisor, flush, hold, reset.
module tb_div_unit_e;

    logic        clk;
    logic        rst;
    logic        div_startE;
    logic        is_signedE;
    logic [31:0] src_aE;
    logic [31:0] src_bE;
    logic        flush_exceptionM;
    logic        ext_stallE;
    logic        alu_stallE;
    logic        div_validE;
    logic [31:0] quotientE;
    logic [31:0] remainderE;

    int n_pass;
    int n_total;

    div_unit_e #(
        .DATA_W (32)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .div_startE       (div_startE),
        .is_signedE       (is_signedE),
        .src_aE           (src_aE),
        .src_bE           (src_bE),
        .flush_exceptionM (flush_exceptionM),
        .ext_stallE       (ext_stallE),
        .alu_stallE       (alu_stallE),
        .div_validE       (div_validE),
        .quotientE        (quotientE),
        .remainderE       (remainderE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts a divide, counts stall cycles, checks the DONE result and optional hold cycles.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic sgn, input logic [31:0] eq, input logic [31:0] er,
                           input int hold);
        int stalls;
        src_aE     = a;
        src_bE     = b;
        is_signedE = sgn;
        div_startE = 1'b1;
        ext_stallE = (hold > 0);
        #1;
        chk({tag, " stall_T"}, {31'b0, alu_stallE}, 32'd1);
        chk({tag, " valid_T"}, {31'b0, div_validE}, 32'd0);
        stalls = 1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (i == 2) begin
                src_aE = 32'hDEAD_BEEF;
                src_bE = 32'h0;
                #1;
            end
            if (!alu_stallE) break;
            stalls++;
        end
        chk({tag, " stalls"}, stalls, 32'd33);
        chk({tag, " valid"}, {31'b0, div_validE}, 32'd1);
        chk({tag, " quo"}, quotientE, eq);
        chk({tag, " rem"}, remainderE, er);
        for (int i = 0; i < hold; i++) begin
            step();
            chk({tag, " hold_valid"}, {31'b0, div_validE}, 32'd1);
            chk({tag, " hold_stall"}, {31'b0, alu_stallE}, 32'd0);
            chk({tag, " hold_quo"}, quotientE, eq);
            chk({tag, " hold_rem"}, remainderE, er);
        end
        ext_stallE = 1'b0;
        step();
        div_startE = 1'b0;
        #1;
        chk({tag, " idle_valid"}, {31'b0, div_validE}, 32'd0);
        chk({tag, " idle_stall"}, {31'b0, alu_stallE}, 32'd0);
    endtask

    initial begin
        n_pass           = 0;
        n_total          = 0;
        rst              = 1'b1;
        div_startE       = 1'b0;
        is_signedE       = 1'b0;
        src_aE           = '0;
        src_bE           = '0;
        flush_exceptionM = 1'b0;
        ext_stallE       = 1'b0;
        step();
        step();
        chk("rst stall", {31'b0, alu_stallE}, 32'd0);
        chk("rst valid", {31'b0, div_validE}, 32'd0);
        chk("rst quo", quotientE, 32'd0);
        chk("rst rem", remainderE, 32'd0);
        rst = 1'b0;
        step();

        run_div("divu 100/7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 0);
        run_div("div -7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
        run_div("div 7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 0);
        run_div("div -7/-2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 32'd3, 32'hFFFF_FFFF, 0);
        run_div("div ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 0);
        run_div("divu ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 0);
        run_div("divu big", 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 32'd1, 32'h7FFF_FFFE, 0);

        // Zero divisor, E advancing: result usable combinationally in the start cycle.
        src_aE     = 32'd5;
        src_bE     = 32'd0;
        is_signedE = 1'b0;
        div_startE = 1'b1;
        #1;
        chk("div0 stall", {31'b0, alu_stallE}, 32'd0);
        chk("div0 valid", {31'b0, div_validE}, 32'd1);
        chk("div0 quo", quotientE, 32'hFFFF_FFFF);
        chk("div0 rem", remainderE, 32'd5);
        step();
        div_startE = 1'b0;
        #1;
        chk("div0 after valid", {31'b0, div_validE}, 32'd0);

        // Zero divisor with E held: DONE holds the result after the start operands change.
        src_aE     = 32'hFFFF_FFF0;
        is_signedE = 1'b1;
        div_startE = 1'b1;
        ext_stallE = 1'b1;
        #1;
        chk("div0h valid_T", {31'b0, div_validE}, 32'd1);
        step();
        div_startE = 1'b0;
        src_aE     = 32'd0;
        ext_stallE = 1'b0;
        #1;
        chk("div0h done_valid", {31'b0, div_validE}, 32'd1);
        chk("div0h done_quo", quotientE, 32'hFFFF_FFFF);
        chk("div0h done_rem", remainderE, 32'hFFFF_FFF0);
        step();
        chk("div0h idle_valid", {31'b0, div_validE}, 32'd0);

        // Flush at BUSY cycle 10.
        src_aE     = 32'd1000;
        src_bE     = 32'd3;
        is_signedE = 1'b0;
        div_startE = 1'b1;
        #1;
        chk("flush stall_T", {31'b0, alu_stallE}, 32'd1);
        for (int i = 0; i < 10; i++) step();
        chk("flush busy_stall", {31'b0, alu_stallE}, 32'd1);
        flush_exceptionM = 1'b1;
        #1;
        chk("flush same_cycle_stall", {31'b0, alu_stallE}, 32'd0);
        step();
        flush_exceptionM = 1'b0;
        div_startE       = 1'b0;
        #1;
        chk("flush idle_stall", {31'b0, alu_stallE}, 32'd0);
        chk("flush idle_valid", {31'b0, div_validE}, 32'd0);
        run_div("divu 9/3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 0);

        // DONE held five cycles with start still high.
        run_div("hold 100/7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 5);

        // Reset mid-operation.
        src_aE     = 32'd50;
        src_bE     = 32'd5;
        div_startE = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) step();
        rst        = 1'b1;
        div_startE = 1'b0;
        step();
        chk("midrst stall", {31'b0, alu_stallE}, 32'd0);
        chk("midrst valid", {31'b0, div_validE}, 32'd0);
        chk("midrst quo", quotientE, 32'd0);
        rst = 1'b0;
        step();
        chk("midrst idle_stall", {31'b0, alu_stallE}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
